dmem_arbiter: RTL and testbench

Arbitrates the single-port data memory (DATA_MEM_DEPTH = 1024 words) between the pipeline MEM stage (core port) and an external loader/debug port (ext port). The core has priority, but a starvation counter guarantees ext progress, and an ext lock supports uninterrupted bursts. When the core loses the memory, the block raises a stall that freezes the pipeline. Sits between the MEM stage and the data memory macro, which has a 1-cycle synchronous read.

---
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Data memory arbiter: shares the single-port data memory between the
// pipeline MEM stage (core) and an external loader/debug port (ext).
// The core normally wins, a saturating starvation counter forces an ext win,
// and ext_lock_i lets ext hold the memory for an uninterrupted burst.
module dmem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    core_req_i,
    input  logic                    core_we_i,
    input  logic [ADDR_WIDTH-1:0]   core_addr_i,
    input  logic [DATA_WIDTH-1:0]   core_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] core_be_i,
    output logic                    core_stall_o,
    output logic                    core_rvalid_o,
    output logic [DATA_WIDTH-1:0]   core_rdata_o,
    input  logic                    ext_req_i,
    input  logic                    ext_we_i,
    input  logic [ADDR_WIDTH-1:0]   ext_addr_i,
    input  logic [DATA_WIDTH-1:0]   ext_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] ext_be_i,
    input  logic                    ext_lock_i,
    output logic                    ext_gnt_o,
    output logic                    ext_rvalid_o,
    output logic [DATA_WIDTH-1:0]   ext_rdata_o,
    output logic                    mem_en_o,
    output logic [DATA_WIDTH/8-1:0] mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic {
        ARB,
        EXT_LOCK
    } arbState_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CORE = 2'd1,
        EXT  = 2'd2
    } rdOwner_e;

    arbState_e  state_q, state_d;
    logic [3:0] starveCnt_q, starveCnt_d;
    rdOwner_e   rdOwner_q, rdOwner_d;
    logic       coreGnt;
    logic       extGnt;

    // Pick this cycle's winner and the next arbiter state; while reset is held
    // nobody is granted so no memory access can leak out
    always_comb begin
        state_d = state_q;
        coreGnt = 1'b0;
        extGnt  = 1'b0;
        if (rst_n) begin
            case (state_q)
                ARB: begin
                    if (ext_req_i && (!core_req_i || starveCnt_q == STARVE_MAX)) begin
                        extGnt = 1'b1;
                        if (ext_lock_i) begin
                            state_d = EXT_LOCK;
                        end
                    end else if (core_req_i) begin
                        coreGnt = 1'b1;
                    end
                end
                EXT_LOCK: begin
                    extGnt = ext_req_i;
                    if (!ext_lock_i) begin
                        state_d = ARB;
                    end
                end
                default: begin
                    state_d = ARB;
                end
            endcase
        end
    end

    // Count consecutive denied ext cycles, saturating at the limit so the
    // forced-win compare stays true until ext is actually served
    always_comb begin
        starveCnt_d = 4'd0;
        if (ext_req_i && !extGnt) begin
            if (starveCnt_q == STARVE_MAX) begin
                starveCnt_d = starveCnt_q;
            end else begin
                starveCnt_d = starveCnt_q + 4'd1;
            end
        end
    end

    // Steer the winner onto the memory port and remember who owns the read
    // data that the memory will return next cycle
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        rdOwner_d   = NONE;
        if (extGnt) begin
            mem_en_o    = 1'b1;
            mem_addr_o  = ext_addr_i;
            mem_wdata_o = ext_wdata_i;
            mem_we_o    = ext_we_i ? ext_be_i : {BE_WIDTH{1'b0}};
            rdOwner_d   = ext_we_i ? NONE : EXT;
        end else if (coreGnt) begin
            mem_en_o    = 1'b1;
            mem_addr_o  = core_addr_i;
            mem_wdata_o = core_wdata_i;
            mem_we_o    = core_we_i ? core_be_i : {BE_WIDTH{1'b0}};
            rdOwner_d   = core_we_i ? NONE : CORE;
        end
    end

    // Stall, accept and read-return outputs; rdata is zeroed on the port
    // that does not own the returning word
    always_comb begin
        core_stall_o  = rst_n && core_req_i && !coreGnt;
        ext_gnt_o     = extGnt;
        core_rvalid_o = (rdOwner_q == CORE);
        ext_rvalid_o  = (rdOwner_q == EXT);
        core_rdata_o  = core_rvalid_o ? mem_rdata_i : '0;
        ext_rdata_o   = ext_rvalid_o ? mem_rdata_i : '0;
    end

    // State, starvation counter and read-owner registers; reset drops any
    // in-flight read so no rvalid appears after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB;
            starveCnt_q <= 4'd0;
            rdOwner_q   <= NONE;
        end else begin
            state_q     <= state_d;
            starveCnt_q <= starveCnt_d;
            rdOwner_q   <= rdOwner_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural 1-cycle-read memory
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        core_req_i;
    logic        core_we_i;
    logic [9:0]  core_addr_i;
    logic [31:0] core_wdata_i;
    logic [3:0]  core_be_i;
    logic        core_stall_o;
    logic        core_rvalid_o;
    logic [31:0] core_rdata_o;
    logic        ext_req_i;
    logic        ext_we_i;
    logic [9:0]  ext_addr_i;
    logic [31:0] ext_wdata_i;
    logic [3:0]  ext_be_i;
    logic        ext_lock_i;
    logic        ext_gnt_o;
    logic        ext_rvalid_o;
    logic [31:0] ext_rdata_o;
    logic        mem_en_o;
    logic [3:0]  mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] memRdata;

    logic [31:0] memModel [0:1023];

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    dmem_arbiter #(
        .DATA_WIDTH  (32),
        .ADDR_WIDTH  (10),
        .STARVE_LIMIT(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_addr_i  (core_addr_i),
        .core_wdata_i (core_wdata_i),
        .core_be_i    (core_be_i),
        .core_stall_o (core_stall_o),
        .core_rvalid_o(core_rvalid_o),
        .core_rdata_o (core_rdata_o),
        .ext_req_i    (ext_req_i),
        .ext_we_i     (ext_we_i),
        .ext_addr_i   (ext_addr_i),
        .ext_wdata_i  (ext_wdata_i),
        .ext_be_i     (ext_be_i),
        .ext_lock_i   (ext_lock_i),
        .ext_gnt_o    (ext_gnt_o),
        .ext_rvalid_o (ext_rvalid_o),
        .ext_rdata_o  (ext_rdata_o),
        .mem_en_o     (mem_en_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (memRdata)
    );

    // Free-running 10-time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory macro model: contents preloaded while reset is held, byte-masked
    // writes, and read data one cycle after a read enable
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) begin
                memModel[i] <= 32'h1000_0000 + 32'(i);
            end
            memModel[10'h005] <= 32'hDEAD_BEEF;
            memModel[10'h020] <= 32'h1234_5678;
        end else if (mem_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we_o[b]) begin
                    memModel[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end
            end
            if (mem_we_o == 4'b0000) begin
                memRdata <= memModel[mem_addr_o];
            end
        end
    end

    task automatic applyStimulus(
        input logic        cReq,
        input logic        cWe,
        input logic [9:0]  cAddr,
        input logic [31:0] cWdata,
        input logic [3:0]  cBe,
        input logic        eReq,
        input logic        eWe,
        input logic [9:0]  eAddr,
        input logic [31:0] eWdata,
        input logic [3:0]  eBe,
        input logic        eLock
    );
        @(negedge clk);
        core_req_i   = cReq;
        core_we_i    = cWe;
        core_addr_i  = cAddr;
        core_wdata_i = cWdata;
        core_be_i    = cBe;
        ext_req_i    = eReq;
        ext_we_i     = eWe;
        ext_addr_i   = eAddr;
        ext_wdata_i  = eWdata;
        ext_be_i     = eBe;
        ext_lock_i   = eLock;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Directed sequence of stimulus steps with hand-computed expectations
    initial begin
        rst_n        = 1'b0;
        core_req_i   = 1'b1;
        core_we_i    = 1'b0;
        core_addr_i  = 10'h007;
        core_wdata_i = 32'h0;
        core_be_i    = 4'hF;
        ext_req_i    = 1'b1;
        ext_we_i     = 1'b1;
        ext_addr_i   = 10'h009;
        ext_wdata_i  = 32'h5555_5555;
        ext_be_i     = 4'hF;
        ext_lock_i   = 1'b1;

        // Reset state with both ports requesting
        #7;
        checkOutput("rst_core_stall", 32'(core_stall_o), 32'd0);
        checkOutput("rst_ext_gnt", 32'(ext_gnt_o), 32'd0);
        checkOutput("rst_mem_en", 32'(mem_en_o), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we_o), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata_o, 32'd0);
        checkOutput("rst_core_rvalid", 32'(core_rvalid_o), 32'd0);
        checkOutput("rst_ext_rvalid", 32'(ext_rvalid_o), 32'd0);
        checkOutput("rst_core_rdata", core_rdata_o, 32'd0);
        checkOutput("rst_ext_rdata", ext_rdata_o, 32'd0);
        @(negedge clk);
        rst_n       = 1'b1;
        core_req_i  = 1'b0;
        ext_req_i   = 1'b0;
        ext_lock_i  = 1'b0;

        // Core-only read of address 5
        applyStimulus(1'b1, 1'b0, 10'h005, 32'h0, 4'hF, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        checkOutput("core_rd_mem_en", 32'(mem_en_o), 32'd1);
        checkOutput("core_rd_mem_addr", 32'(mem_addr_o), 32'h005);
        checkOutput("core_rd_mem_we", 32'(mem_we_o), 32'd0);
        checkOutput("core_rd_stall", 32'(core_stall_o), 32'd0);
        idleCycle();
        checkOutput("core_rd_rvalid", 32'(core_rvalid_o), 32'd1);
        checkOutput("core_rd_rdata", core_rdata_o, 32'hDEAD_BEEF);
        checkOutput("core_rd_ext_rvalid", 32'(ext_rvalid_o), 32'd0);
        checkOutput("core_rd_stall_n1", 32'(core_stall_o), 32'd0);
        checkOutput("idle_mem_en", 32'(mem_en_o), 32'd0);

        // Contention: four core wins, then the starved ext read is forced in
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 10'h001, 32'h0, 4'hF, 1'b1, 1'b0, 10'h002, 32'h0, 4'hF, 1'b0);
            checkOutput($sformatf("cont_ext_gnt_%0d", i), 32'(ext_gnt_o), 32'd0);
            checkOutput($sformatf("cont_stall_%0d", i), 32'(core_stall_o), 32'd0);
            checkOutput($sformatf("cont_addr_%0d", i), 32'(mem_addr_o), 32'h001);
        end
        applyStimulus(1'b1, 1'b0, 10'h001, 32'h0, 4'hF, 1'b1, 1'b0, 10'h002, 32'h0, 4'hF, 1'b0);
        checkOutput("cont5_ext_gnt", 32'(ext_gnt_o), 32'd1);
        checkOutput("cont5_stall", 32'(core_stall_o), 32'd1);
        checkOutput("cont5_addr", 32'(mem_addr_o), 32'h002);
        checkOutput("cont5_core_rdata", core_rdata_o, 32'h1000_0001);
        applyStimulus(1'b1, 1'b0, 10'h001, 32'h0, 4'hF, 1'b1, 1'b0, 10'h002, 32'h0, 4'hF, 1'b0);
        checkOutput("cont6_ext_gnt", 32'(ext_gnt_o), 32'd0);
        checkOutput("cont6_stall", 32'(core_stall_o), 32'd0);
        checkOutput("cont6_ext_rvalid", 32'(ext_rvalid_o), 32'd1);
        checkOutput("cont6_ext_rdata", ext_rdata_o, 32'h1000_0002);
        checkOutput("cont6_core_rdata", core_rdata_o, 32'd0);
        idleCycle();
        checkOutput("cont7_core_rdata", core_rdata_o, 32'h1000_0001);

        // Lock burst: ext wins by starvation, then holds the memory for 3 writes
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 10'h003, 32'h0, 4'hF, 1'b1, 1'b1, 10'h010, 32'h11, 4'hF, 1'b1);
            checkOutput($sformatf("lockwait_gnt_%0d", i), 32'(ext_gnt_o), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 10'h003, 32'h0, 4'hF, 1'b1, 1'b1, 10'h010 + 10'(i),
                          32'h11 * 32'(i + 1), 4'hF, 1'b1);
            checkOutput($sformatf("lock_gnt_%0d", i), 32'(ext_gnt_o), 32'd1);
            checkOutput($sformatf("lock_stall_%0d", i), 32'(core_stall_o), 32'd1);
            checkOutput($sformatf("lock_we_%0d", i), 32'(mem_we_o), 32'hF);
            checkOutput($sformatf("lock_addr_%0d", i), 32'(mem_addr_o), 32'h010 + 32'(i));
            checkOutput($sformatf("lock_wdata_%0d", i), mem_wdata_o, 32'h11 * 32'(i + 1));
        end
        applyStimulus(1'b1, 1'b0, 10'h003, 32'h0, 4'hF, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        checkOutput("unlock_stall", 32'(core_stall_o), 32'd1);
        checkOutput("unlock_mem_en", 32'(mem_en_o), 32'd0);
        checkOutput("unlock_rvalid", 32'(core_rvalid_o), 32'd0);
        applyStimulus(1'b1, 1'b0, 10'h003, 32'h0, 4'hF, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        checkOutput("after_lock_stall", 32'(core_stall_o), 32'd0);
        checkOutput("after_lock_addr", 32'(mem_addr_o), 32'h003);
        idleCycle();
        checkOutput("after_lock_rdata", core_rdata_o, 32'h1000_0003);

        // Byte write to address 0x20, then core read and ext read back to back
        applyStimulus(1'b1, 1'b1, 10'h020, 32'hAABB_CCDD, 4'b0010, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        checkOutput("bw_mem_we", 32'(mem_we_o), 32'b0010);
        checkOutput("bw_mem_wdata", mem_wdata_o, 32'hAABB_CCDD);
        checkOutput("bw_mem_addr", 32'(mem_addr_o), 32'h020);
        applyStimulus(1'b1, 1'b0, 10'h020, 32'h0, 4'hF, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        checkOutput("bw_no_rvalid", 32'(core_rvalid_o), 32'd0);
        checkOutput("b2b_core_en", 32'(mem_en_o), 32'd1);
        applyStimulus(1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b1, 1'b0, 10'h012, 32'h0, 4'hF, 1'b0);
        checkOutput("b2b_ext_gnt", 32'(ext_gnt_o), 32'd1);
        checkOutput("b2b_core_rvalid", 32'(core_rvalid_o), 32'd1);
        checkOutput("b2b_core_rdata", core_rdata_o, 32'h1234_CC78);
        checkOutput("b2b_ext_rdata_0", ext_rdata_o, 32'd0);
        idleCycle();
        checkOutput("b2b_ext_rvalid", 32'(ext_rvalid_o), 32'd1);
        checkOutput("b2b_ext_rdata", ext_rdata_o, 32'h0000_0033);
        checkOutput("b2b_core_rvalid_0", 32'(core_rvalid_o), 32'd0);
        checkOutput("b2b_core_rdata_0", core_rdata_o, 32'd0);

        // Reset asserted in the cycle after a core read grant
        applyStimulus(1'b1, 1'b0, 10'h005, 32'h0, 4'hF, 1'b0, 1'b0, 10'h0, 32'h0, 4'h0, 1'b0);
        checkOutput("mid_rd_en", 32'(mem_en_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_rvalid", 32'(core_rvalid_o), 32'd0);
        checkOutput("mid_rst_rdata", core_rdata_o, 32'd0);
        checkOutput("mid_rst_stall", 32'(core_stall_o), 32'd0);
        checkOutput("mid_rst_mem_en", 32'(mem_en_o), 32'd0);
        checkOutput("mid_rst_mem_addr", 32'(mem_addr_o), 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        core_req_i = 1'b0;
        idleCycle();
        checkOutput("post_rst_core_rvalid", 32'(core_rvalid_o), 32'd0);
        checkOutput("post_rst_ext_rvalid", 32'(ext_rvalid_o), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
